// File: rtl/ibex_dummy_instr_retire_pkg.sv
// Shared constants and helpers for the dummy-instruction retire tracker.
// Also holds the encoding rules for legal dummy instructions.
package ibex_dummy_instr_retire_pkg;

   localparam logic [6:0] OPCODE_OP = 7'h33;

   // Dummy funct constants packed as {funct7, funct3}.
   localparam logic [9:0] DUMMY_FUNCT_ADD = {7'h00, 3'b000};
   localparam logic [9:0] DUMMY_FUNCT_MUL = {7'h01, 3'b000};
   localparam logic [9:0] DUMMY_FUNCT_DIV = {7'h01, 3'b100};
   localparam logic [9:0] DUMMY_FUNCT_AND = {7'h00, 3'b111};

   // Matches the inserter's 2-bit op select.
   typedef enum logic [1:0] {
      DUMMY_ADD = 2'b00,
      DUMMY_MUL = 2'b01,
      DUMMY_DIV = 2'b10,
      DUMMY_AND = 2'b11
   } dummy_op_e;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rtype_instr_t;

   function automatic logic [9:0] dummyFunct(input dummy_op_e op);
      logic [9:0] funct;
      unique case (op)
         DUMMY_ADD: funct = DUMMY_FUNCT_ADD;
         DUMMY_MUL: funct = DUMMY_FUNCT_MUL;
         DUMMY_DIV: funct = DUMMY_FUNCT_DIV;
         default:   funct = DUMMY_FUNCT_AND;
      endcase
      return funct;
   endfunction

   // A dummy must be an R-type OP writing x0 with one of the inserter's four functs.
   function automatic logic isLegalDummy(input logic [31:0] instr);
      rtype_instr_t r;
      logic [9:0]   functSel;
      logic         functOk;
      r        = rtype_instr_t'(instr);
      functSel = {r.funct7, r.funct3};
      functOk  = (functSel == dummyFunct(DUMMY_ADD)) ||
                 (functSel == dummyFunct(DUMMY_MUL)) ||
                 (functSel == dummyFunct(DUMMY_DIV)) ||
                 (functSel == dummyFunct(DUMMY_AND));
      return (r.opcode == OPCODE_OP) && (r.rd == 5'd0) && functOk;
   endfunction

endpackage

// File: rtl/ibex_dummy_instr_retire_tag.sv
// In-order 1-bit tag FIFO (ibex_dummy_tag_fifo) tracking the dummy flag of
// every in-flight instruction between issue and retire.
module ibex_dummy_tag_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic data_i,
   input  logic pop_i,
   input  logic flush_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             pushEn, popEn;

   assign full_o  = (occ_q == OCC_W'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign head_o  = mem_q[rdPtr_q];

   assign pushEn = push_i && !full_o;
   assign popEn  = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap naturally at their width.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      occ_d   = occ_q;
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         occ_d   = '0;
      end else begin
         if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         unique case ({pushEn, popEn})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         occ_q   <= '0;
         mem_q   <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         occ_q   <= occ_d;
         if (pushEn && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/ibex_dummy_instr_retire.sv
// Retire-side dummy tracker: tags issued instructions, reports dummies at
// retire, counts retired dummies and flags malformed or unbalanced traffic.
module ibex_dummy_instr_retire
   import ibex_dummy_instr_retire_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_valid_i,
   input  logic             issue_dummy_i,
   input  logic [31:0]      issue_instr_i,
   output logic             issue_ready_o,
   input  logic             retire_valid_i,
   input  logic             flush_i,
   input  logic             count_clr_i,
   output logic             retire_dummy_o,
   output logic             instret_real_o,
   output logic [CNT_W-1:0] dummy_retired_cnt_o,
   output logic             dummy_form_err_o,
   output logic             underflow_err_o
);

   logic             tagFull, tagEmpty, tagHead;
   logic             issueAccept, popValid;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             formErr_q, formErr_d;
   logic             underflow_q, underflow_d;

   // Ready depends only on registered occupancy, never on a same-cycle retire.
   assign issue_ready_o = !tagFull;
   assign issueAccept   = issue_valid_i && issue_ready_o;
   assign popValid      = retire_valid_i && !tagEmpty;

   ibex_dummy_tag_fifo #(
      .DEPTH(DEPTH)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (issueAccept),
      .data_i  (issue_dummy_i),
      .pop_i   (retire_valid_i),
      .flush_i (flush_i),
      .full_o  (tagFull),
      .empty_o (tagEmpty),
      .head_o  (tagHead)
   );

   assign retire_dummy_o = !tagEmpty && tagHead;
   assign instret_real_o = popValid && !tagHead;

   // A flush still lets the same-cycle retire count; clear beats increment.
   always_comb begin
      cnt_d       = cnt_q;
      formErr_d   = formErr_q;
      underflow_d = underflow_q;
      if (count_clr_i) begin
         cnt_d = '0;
      end else if (popValid && tagHead && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (issueAccept && issue_dummy_i && !isLegalDummy(issue_instr_i)) begin
         formErr_d = 1'b1;
      end
      if (retire_valid_i && tagEmpty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         formErr_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         formErr_q   <= formErr_d;
         underflow_q <= underflow_d;
      end
   end

   assign dummy_retired_cnt_o = cnt_q;
   assign dummy_form_err_o    = formErr_q;
   assign underflow_err_o     = underflow_q;

endmodule

// File: tb/tb_ibex_dummy_instr_retire.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_ibex_dummy_instr_retire;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   localparam logic [31:0] REAL_INSTR = 32'h0010_0093;
   localparam logic [31:0] ADD_DUMMY  = 32'h0040_8033;
   localparam logic [31:0] BAD_DUMMY  = 32'h0000_02B3;

   logic             clk;
   logic             rst;
   logic             issueValid, issueDummy, retireValid, flush, countClr;
   logic [31:0]      issueInstr;
   logic             issueReady, retireDummy, instretReal, formErr, underflowErr;
   logic [CNT_W-1:0] dummyCnt;

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   bit tagQ[$];
   int mCnt;
   bit mForm, mUf;

   logic [31:0] legalTmpl [4];

   ibex_dummy_instr_retire #(
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .issue_valid_i       (issueValid),
      .issue_dummy_i       (issueDummy),
      .issue_instr_i       (issueInstr),
      .issue_ready_o       (issueReady),
      .retire_valid_i      (retireValid),
      .flush_i             (flush),
      .count_clr_i         (countClr),
      .retire_dummy_o      (retireDummy),
      .instret_real_o      (instretReal),
      .dummy_retired_cnt_o (dummyCnt),
      .dummy_form_err_o    (formErr),
      .underflow_err_o     (underflowErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Legal dummies, viewed as full instruction words with rs1/rs2 masked off.
   function automatic bit legalModel(input logic [31:0] instr);
      logic [31:0] k;
      k = instr & 32'hFE00_7FFF;
      return (k == 32'h0000_0033) || (k == 32'h0200_0033) ||
             (k == 32'h0200_4033) || (k == 32'h0000_7033);
   endfunction

   // Advances the model by one clock edge using the inputs currently applied.
   task automatic modelStep();
      int sz;
      bit accept;
      bit b;
      if (rst) begin
         tagQ.delete();
         mCnt  = 0;
         mForm = 1'b0;
         mUf   = 1'b0;
      end else begin
         sz     = tagQ.size();
         accept = issueValid && (sz < DEPTH);
         if (retireValid) begin
            if (sz == 0) begin
               mUf = 1'b1;
            end else begin
               b = tagQ.pop_front();
               if (b && mCnt < CNT_MAX) mCnt++;
            end
         end
         if (countClr) mCnt = 0;
         if (accept && issueDummy && !legalModel(issueInstr)) mForm = 1'b1;
         if (flush) tagQ.delete();
         else if (accept) tagQ.push_back(issueDummy);
      end
   endtask

   // Inputs change just after posedge, so negedge sees settled outputs.
   always @(negedge clk) begin
      int sz;
      if (checkEn) begin
         sz = tagQ.size();
         checkOutput("issue_ready", 32'(issueReady), 32'(sz < DEPTH));
         checkOutput("retire_dummy", 32'(retireDummy), 32'((sz > 0) ? tagQ[0] : 1'b0));
         checkOutput("instret_real", 32'(instretReal),
                     32'(retireValid && (sz > 0) && !tagQ[0]));
         checkOutput("dummy_cnt", 32'(dummyCnt), 32'(mCnt));
         checkOutput("form_err", 32'(formErr), 32'(mForm));
         checkOutput("underflow_err", 32'(underflowErr), 32'(mUf));
         modelStep();
      end
   end

   task automatic applyStimulus(input logic r, input logic iv, input logic id,
                                input logic [31:0] instr, input logic rv,
                                input logic fl, input logic clr);
      @(posedge clk);
      #1;
      rst         = r;
      issueValid  = iv;
      issueDummy  = id;
      issueInstr  = instr;
      retireValid = rv;
      flush       = fl;
      countClr    = clr;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic issueOne(input logic id, input logic [31:0] instr);
      applyStimulus(1'b0, 1'b1, id, instr, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic retireOne();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      legalTmpl[0] = 32'h0000_0033;
      legalTmpl[1] = 32'h0200_0033;
      legalTmpl[2] = 32'h0200_4033;
      legalTmpl[3] = 32'h0000_7033;
      rst = 1'b1; issueValid = 1'b0; issueDummy = 1'b0; issueInstr = '0;
      retireValid = 1'b0; flush = 1'b0; countClr = 1'b0;
      mCnt = 0; mForm = 1'b0; mUf = 1'b0;
      @(posedge clk);
      #1 checkEn = 1'b1;

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("reset_ready", 32'(issueReady), 32'd1);
      checkOutput("reset_cnt", 32'(dummyCnt), 32'd0);
      checkOutput("reset_retire_dummy", 32'(retireDummy), 32'd0);
      checkOutput("reset_errs", 32'({formErr, underflowErr}), 32'd0);

      // real, dummy ADD, real, then three retires
      issueOne(1'b0, REAL_INSTR);
      issueOne(1'b1, ADD_DUMMY);
      issueOne(1'b0, REAL_INSTR);
      retireOne(); #2;
      checkOutput("seq1_dummy", 32'(retireDummy), 32'd0);
      checkOutput("seq1_real", 32'(instretReal), 32'd1);
      retireOne(); #2;
      checkOutput("seq2_dummy", 32'(retireDummy), 32'd1);
      checkOutput("seq2_real", 32'(instretReal), 32'd0);
      retireOne(); #2;
      checkOutput("seq3_dummy", 32'(retireDummy), 32'd0);
      checkOutput("seq3_real", 32'(instretReal), 32'd1);
      idle(); #2;
      checkOutput("seq_cnt", 32'(dummyCnt), 32'd1);
      checkOutput("model_cnt_pin", 32'(mCnt), 32'd1);

      // fill to DEPTH, then retire+issue together
      for (int i = 0; i < DEPTH; i++) issueOne(1'b0, REAL_INSTR);
      idle(); #2;
      checkOutput("full_ready", 32'(issueReady), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, REAL_INSTR, 1'b1, 1'b0, 1'b0); #2;
      checkOutput("full_pop_ready", 32'(issueReady), 32'd0);
      idle(); #2;
      checkOutput("after_pop_ready", 32'(issueReady), 32'd1);
      issueOne(1'b0, REAL_INSTR);
      idle(); #2;
      checkOutput("refull_ready", 32'(issueReady), 32'd0);
      checkOutput("model_occ_pin", 32'(tagQ.size()), 32'd4);
      for (int i = 0; i < DEPTH; i++) retireOne();

      // malformed dummy (rd = 5)
      issueOne(1'b1, BAD_DUMMY);
      idle(); #2;
      checkOutput("form_err_set", 32'(formErr), 32'd1);
      retireOne(); #2;
      checkOutput("bad_dummy_retire", 32'(retireDummy), 32'd1);
      idle(); #2;
      checkOutput("bad_dummy_cnt", 32'(dummyCnt), 32'd2);
      checkOutput("form_err_sticky", 32'(formErr), 32'd1);

      // retire while empty
      retireOne(); #2;
      checkOutput("uf_real", 32'(instretReal), 32'd0);
      idle(); #2;
      checkOutput("uf_set", 32'(underflowErr), 32'd1);
      checkOutput("uf_cnt", 32'(dummyCnt), 32'd2);

      // flush + retire + issue with head dummy
      issueOne(1'b1, ADD_DUMMY);
      issueOne(1'b0, REAL_INSTR);
      issueOne(1'b0, REAL_INSTR);
      applyStimulus(1'b0, 1'b1, 1'b1, ADD_DUMMY, 1'b1, 1'b1, 1'b0);
      idle(); #2;
      checkOutput("flush_cnt", 32'(dummyCnt), 32'd3);
      checkOutput("flush_empty", 32'(retireDummy), 32'd0);
      retireOne(); #2;
      checkOutput("flush_dropped", 32'(instretReal), 32'd0);

      // saturation then clear
      for (int i = 0; i < 12; i++) begin
         issueOne(1'b1, ADD_DUMMY);
         retireOne();
      end
      idle(); #2;
      checkOutput("sat_reach", 32'(dummyCnt), 32'd15);
      issueOne(1'b1, ADD_DUMMY);
      retireOne();
      idle(); #2;
      checkOutput("sat_hold", 32'(dummyCnt), 32'd15);
      issueOne(1'b1, ADD_DUMMY);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      idle(); #2;
      checkOutput("clr_wins", 32'(dummyCnt), 32'd0);

      // reset mid-operation
      issueOne(1'b1, ADD_DUMMY);
      issueOne(1'b0, REAL_INSTR);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      idle(); #2;
      checkOutput("midrst_dummy", 32'(retireDummy), 32'd0);
      checkOutput("midrst_errs", 32'({formErr, underflowErr}), 32'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, iv, id, rv, fl, clr;
         logic [31:0] instr;
         r   = ($urandom_range(0, 199) == 0);
         iv  = ($urandom_range(0, 9) < 6);
         id  = $urandom_range(0, 1);
         rv  = ($urandom_range(0, 1) == 1);
         fl  = ($urandom_range(0, 32) == 0);
         clr = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) < 7)
            instr = legalTmpl[$urandom_range(0, 3)] | ($urandom & 32'h01FF_8000);
         else
            instr = $urandom;
         if (fl && id && !legalModel(instr)) id = 1'b0;
         applyStimulus(r, iv, id, instr, rv, fl, clr);
      end
      idle();
      @(posedge clk);
      #1 checkEn = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ibex_dummy_instr_retire.md
# ibex_dummy_instr_retire

Retire-side counterpart of the dummy instruction inserter. It tracks which in-flight instructions were inserted as dummies, from ID issue to WB retire, using an in-order tag FIFO. At retire it tells the core whether each instruction is a dummy, so `minstret` and other architectural counters skip dummies. It also counts retired dummies and flags malformed or unbalanced dummy traffic. It sits beside the ID/EX/WB pipeline, fed by the ID issue handshake and the WB retire strobe.

## Interface
Parameters:
- `DEPTH`, 4: in-flight tag slots; power of two, at least 2.
- `CNT_W`, 32: width of the retired-dummy counter.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `issue_valid_i`, in, 1: an instruction is accepted from ID into EX this cycle.
- `issue_dummy_i`, in, 1: the issued instruction came from the dummy inserter.
- `issue_instr_i`, in, 32: the issued instruction word.
- `issue_ready_o`, out, 1: a tag slot is free; ID must not issue while this is low.
- `retire_valid_i`, in, 1: the oldest in-flight instruction retires this cycle.
- `flush_i`, in, 1: pipeline flush; all in-flight tags are discarded.
- `count_clr_i`, in, 1: clears the retired-dummy counter.
- `retire_dummy_o`, out, 1: the head tag is a dummy; combinational from FIFO state.
- `instret_real_o`, out, 1: a non-dummy instruction retired this cycle.
- `dummy_retired_cnt_o`, out, CNT_W: number of retired dummies; saturating.
- `dummy_form_err_o`, out, 1: sticky; a dummy was issued with an illegal encoding.
- `underflow_err_o`, out, 1: sticky; a retire arrived while the FIFO was empty.

## Operation
- **Tag FIFO:** DEPTH entries of 1 bit each (the dummy flag), with a wrapping read pointer, write pointer and occupancy counter of width log2(DEPTH)+1.
- **Push:** on `issue_valid_i && issue_ready_o`, push `issue_dummy_i`.
- **Pop:** on `retire_valid_i` with the FIFO non-empty, pop.
  - If the popped flag is 1, `dummy_retired_cnt_o` increments, saturating at all-ones.
  - If the popped flag is 0, `instret_real_o` pulses.
- **Legal dummy encoding:**
  - `opcode` = 7'h33 and `rd` = 0.
  - `{funct7,funct3}` is one of: {7'h00,3'b000} (ADD), {7'h01,3'b000} (MUL), {7'h01,3'b100} (DIV), {7'h00,3'b111} (AND).
  - A push with `issue_dummy_i` = 1 and any other encoding sets `dummy_form_err_o`. The entry is still pushed as a dummy.
- **Underflow:** `retire_valid_i` with the FIFO empty sets `underflow_err_o`. Nothing pops, the counter does not change and `instret_real_o` stays 0.
- **Error clearing:** both sticky errors clear only on `rst_i`.
- **Flush:**
  - A retire in the same cycle is processed first, including counting.
  - Then pointers and occupancy go to 0.
  - An issue in the same cycle is discarded.
- **`count_clr_i`:** the counter goes to 0. Clear wins over a same-cycle increment.

## Timing
- **Reset values:**
  - `issue_ready_o` = 1.
  - `retire_dummy_o`, `instret_real_o`, `dummy_retired_cnt_o` and both errors = 0.
  - FIFO empty.
- **`issue_ready_o`:** equals `!full`, registered-state only. It does not account for a same-cycle pop, so there is no combinational path from `retire_valid_i`.
- **Full FIFO:** push blocked. A pop that cycle frees a slot visible the next cycle.
- **Empty FIFO with simultaneous issue and retire:** underflow is flagged and the new entry is pushed. There is no bypass.
- **Non-empty FIFO with simultaneous push and pop:** occupancy is unchanged and both operations are applied.
- **`retire_dummy_o`:** valid whenever the FIFO is non-empty; 0 when empty. The core samples it with `retire_valid_i` in the same cycle.
- **`instret_real_o`:** combinational, qualified by `retire_valid_i` and non-empty; zero-cycle latency.
- **Counter and errors:** update on the clock edge after the event.
- **Reset mid-operation:** everything returns to reset values on the next edge. In-flight tags are lost.

## Structure
- **`ibex_pkg` additions:**
  - `OPCODE_OP` = 7'h33.
  - Dummy funct constants `DUMMY_FUNCT_ADD/MUL/DIV/AND` as 10-bit `{funct7,funct3}`.
  - A `dummy_op_e` enum matching the inserter's 2-bit op select.
- **`ibex_dummy_tag_fifo`:** one sub-module holding the parameterized 1-bit synchronous FIFO with push, pop, flush, full, empty and head.
- **Top level:** encoding check, counter, error flags and retire outputs.

## Test plan
- Reset, then issue real, dummy ADD (32'h0000_0033 with legal rs1/rs2), real, then retire ×3:
  - `retire_dummy_o` is 0, 1, 0 in turn.
  - `instret_real_o` pulses twice.
  - Counter = 1.
- Issue 4 instructions (DEPTH=4) with no retire:
  - `issue_ready_o` drops to 0 after the 4th.
  - Retire + issue in the same cycle: ready returns to 1 the next cycle, and occupancy returns to 4 after the next issue.
- Issue a dummy with `rd`=5 (32'h0000_02B3):
  - `dummy_form_err_o` rises the next cycle and stays high.
  - The entry still retires as a dummy.
- Retire with the FIFO empty:
  - `underflow_err_o` = 1.
  - Counter and `instret_real_o` unchanged.
- With 3 entries (head dummy), assert `flush_i` + `retire_valid_i` + `issue_valid_i`:
  - Counter +1.
  - FIFO empty next cycle and the issued entry dropped.
- Preload the counter near saturation (CNT_W=4, 15 dummies), retire one more dummy: counter stays at 15.
  - Assert `count_clr_i` together with a dummy retire: counter = 0.
